input_sequencer: RTL and testbench

//  Sits between PS2_Manager and the shift_reg/fsm pair; replaces ad-hoc glue logic in top.

---
 rtl/input_seq_pkg.sv | 23 ++
 rtl/input_sequencer_key_fifo.sv | 49 ++++
 rtl/input_sequencer.sv | 151 +++++++++++++++
 tb/tb_input_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_seq_pkg.sv
// Shared types for the key input sequencer: dispatch states, FIFO entry layout, key flag codes.
package input_seq_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_CALC   = 2'd1,
        SHOW_RESULT = 2'd2
    } state_e;

    typedef struct packed {
        logic       is_enter;
        logic [3:0] code;
    } key_entry_t;

    localparam logic [1:0] FLAG_DIGIT = 2'b01;
    localparam logic [1:0] FLAG_ENTER = 2'b10;

    // Only pure digit or pure Enter events are worth queuing.
    function automatic logic flags_ok(input logic [1:0] flags);
        return (flags == FLAG_DIGIT) || (flags == FLAG_ENTER);
    endfunction

endpackage

// File: rtl/input_sequencer_key_fifo.sv
// Small synchronous key FIFO; a push into a full FIFO succeeds only if a pop happens in the same cycle.
module key_fifo
    import input_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  key_entry_t               push_data,
    input  logic                     pop,
    output key_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    key_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/input_sequencer.sv
// Queues PS/2 key events and dispatches digits to shift_reg and Enter to the calc fsm.
// Optional calc_done watchdog enabled by defining INPUT_SEQ_TIMEOUT_EN.
module input_sequencer
    import input_seq_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_DIGITS   = 4,
    parameter int CALC_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic [1:0]                    key_flags,
    output logic                          digit_strobe,
    output logic [3:0]                    digit_data,
    output logic                          sr_clear,
    output logic                          calc_start,
    input  logic                          calc_done,
    output logic                          disp_sel,
    output logic                          busy,
    output logic                          key_dropped,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

    state_e     state, state_d;
    logic [CW-1:0] count, count_d;
    logic       in_vld;
    key_entry_t in_entry;
    key_entry_t head;
    logic       full, empty, pop, tmo_hit;
    logic       digit_strobe_d, sr_clear_d, calc_start_d, disp_sel_d;
    logic [3:0] digit_data_d;

    // Input register keeps the PS/2 strobe off the FIFO write path.
    always_ff @(posedge clk) begin
        if (!reset) in_vld <= 1'b0;
        else        in_vld <= key_valid && flags_ok(key_flags);
        in_entry.is_enter <= (key_flags == FLAG_ENTER);
        in_entry.code     <= key_code;
    end

    key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_vld),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

`ifdef INPUT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(CALC_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(CALC_TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_CALC) && !calc_done && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_CALC) ? tmo_cnt + 1'b1 : '0;
            if (tmo_hit) err_timeout <= 1'b1;
        end
    end
`else
    wire unused_calc_timeout = ^CALC_TIMEOUT;
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state;
        count_d        = count;
        pop            = 1'b0;
        digit_strobe_d = 1'b0;
        digit_data_d   = '0;
        sr_clear_d     = 1'b0;
        calc_start_d   = 1'b0;
        disp_sel_d     = disp_sel;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (!head.is_enter) begin
                    if (count != CNT_MAX) begin
                        digit_strobe_d = 1'b1;
                        digit_data_d   = head.code;
                        count_d        = count + 1'b1;
                    end
                end else if (count != '0) begin
                    calc_start_d = 1'b1;
                    state_d      = WAIT_CALC;
                end
            end
            WAIT_CALC: if (calc_done) begin
                state_d    = SHOW_RESULT;
                disp_sel_d = 1'b1;
            end else if (tmo_hit) begin
                sr_clear_d = 1'b1;
                count_d    = '0;
                disp_sel_d = 1'b0;
                state_d    = IDLE;
            end
            // A digit ends the result view but stays queued for the next IDLE slot.
            SHOW_RESULT: if (!empty) begin
                if (head.is_enter) begin
                    pop = 1'b1;
                end else begin
                    sr_clear_d = 1'b1;
                    count_d    = '0;
                    disp_sel_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            digit_strobe <= 1'b0;
            digit_data   <= '0;
            sr_clear     <= 1'b0;
            calc_start   <= 1'b0;
            disp_sel     <= 1'b0;
            key_dropped  <= 1'b0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            digit_strobe <= digit_strobe_d;
            digit_data   <= digit_data_d;
            sr_clear     <= sr_clear_d;
            calc_start   <= calc_start_d;
            disp_sel     <= disp_sel_d;
            if (in_vld && full && !pop) key_dropped <= 1'b1;
        end
    end

    assign busy = (state == WAIT_CALC);

endmodule

// File: tb/tb_input_sequencer.sv
// Randomised scoreboard bench for input_sequencer against a key-level queue model.
module tb_input_sequencer;
    localparam int DEPTH = 4;
    localparam int MAXD  = 4;
    localparam logic [1:0] F_DIG = 2'b01;
    localparam logic [1:0] F_ENT = 2'b10;
    localparam int M_ENTRY = 0, M_WAIT = 1, M_SHOW = 2;
    localparam int EV_DIG = 0, EV_CLR = 1, EV_START = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic [1:0] key_flags = '0;
    logic       calc_done = 1'b0;
    logic       digit_strobe, sr_clear, calc_start, disp_sel, busy, key_dropped, err_timeout;
    logic [3:0] digit_data;
    logic [2:0] fifo_level;

    input_sequencer #(.FIFO_DEPTH(DEPTH), .MAX_DIGITS(MAXD), .CALC_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_flags(key_flags), .digit_strobe(digit_strobe), .digit_data(digit_data),
        .sr_clear(sr_clear), .calc_start(calc_start), .calc_done(calc_done),
        .disp_sel(disp_sel), .busy(busy), .key_dropped(key_dropped),
        .err_timeout(err_timeout), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int data; } ev_t;
    ev_t exp_q[$];
    int  m_pend[$];          // queued keys: code, or 16+code for Enter
    int  m_mode = M_ENTRY;
    int  m_cnt  = 0;
    int  exp_drop = 0;
    int  exp_err  = 0;
    int  tests = 0;
    int  fails = 0;

    function automatic void chk(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endfunction

    function automatic void push_ev(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Consume queued keys as far as the current mode allows.
    function automatic void model_run();
        int k;
        while (m_pend.size() > 0 && m_mode != M_WAIT) begin
            k = m_pend[0];
            if (m_mode == M_SHOW) begin
                if (k >= 16) void'(m_pend.pop_front());
                else begin
                    push_ev(EV_CLR, 0);
                    m_cnt  = 0;
                    m_mode = M_ENTRY;
                end
            end else begin
                void'(m_pend.pop_front());
                if (k < 16) begin
                    if (m_cnt < MAXD) begin
                        push_ev(EV_DIG, k);
                        m_cnt++;
                    end
                end else if (m_cnt > 0) begin
                    push_ev(EV_START, 0);
                    m_mode = M_WAIT;
                end
            end
        end
    endfunction

    function automatic void model_key(input logic [3:0] code, input logic [1:0] flags);
        if (flags == F_DIG || flags == F_ENT) begin
            if (m_pend.size() >= DEPTH) exp_drop = 1;
            else m_pend.push_back((flags == F_ENT) ? 16 + int'(code) : int'(code));
        end
        model_run();
    endfunction

    function automatic void model_reset();
        m_pend.delete();
        m_mode   = M_ENTRY;
        m_cnt    = 0;
        exp_drop = 0;
        exp_err  = 0;
    endfunction

    function automatic void ev_check(input int kind, input int data);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d data %0d, want none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                fails++;
                $display("FAIL event: got kind %0d data %0d, want kind %0d data %0d",
                         kind, data, e.kind, e.data);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (digit_strobe === 1'b1) ev_check(EV_DIG, int'(digit_data));
        if (sr_clear === 1'b1)     ev_check(EV_CLR, 0);
        if (calc_start === 1'b1)   ev_check(EV_START, 0);
    end

    task automatic drive_key(input logic [3:0] code, input logic [1:0] flags);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = code;
        key_flags = flags;
        model_key(code, flags);
    endtask

    task automatic send_key(input logic [3:0] code, input logic [1:0] flags, input int gap);
        drive_key(code, flags);
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        calc_done = 1'b1;
        if (m_mode == M_WAIT) begin
            m_mode = M_SHOW;
            model_run();
        end
        @(posedge clk); #1;
        calc_done = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy"},     int'(busy),        (m_mode == M_WAIT) ? 1 : 0);
        chk({tag, "_disp_sel"}, int'(disp_sel),    (m_mode == M_SHOW) ? 1 : 0);
        chk({tag, "_level"},    int'(fifo_level),  m_pend.size());
        chk({tag, "_dropped"},  int'(key_dropped), exp_drop);
        chk({tag, "_err"},      int'(err_timeout), exp_err);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strobe"}, int'(digit_strobe), 0);
        chk({tag, "_data"},   int'(digit_data),   0);
        chk({tag, "_clear"},  int'(sr_clear),     0);
        chk({tag, "_start"},  int'(calc_start),   0);
        chk({tag, "_disp"},   int'(disp_sel),     0);
        chk({tag, "_busy"},   int'(busy),         0);
        chk({tag, "_drop"},   int'(key_dropped),  0);
        chk({tag, "_err"},    int'(err_timeout),  0);
        chk({tag, "_level"},  int'(fifo_level),   0);
    endtask

    task automatic do_reset(input string tag);
        chk({tag, "_pending_events"}, exp_q.size(), 0);
        @(posedge clk); #1;
        reset     = 1'b0;
        calc_done = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
        @(negedge clk);
        check_zero(tag);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic rand_key(output logic [3:0] c, output logic [1:0] f);
        int r;
        r = int'($urandom_range(0, 9));
        c = 4'($urandom_range(0, 15));
        if (r < 7)      f = F_DIG;
        else if (r < 9) f = F_ENT;
        else            f = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c;
        logic [1:0] f;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);

        // Latency: strobe appears in the cycle after edge E+2.
        drive_key(4'd1, F_DIG);
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("latency_early", int'(digit_strobe), 0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_hit", int'(digit_strobe), 1);
        repeat (3) @(posedge clk);
        send_key(4'd2, F_DIG, 5);
        send_key(4'd0, F_ENT, 5);
        settle_check("t1_enter");

        pulse_done();
        settle_check("t2_done");
        send_key(4'd7, F_DIG, 5);
        settle_check("t2_next");

        send_key(4'd3, F_DIG, 5);
        send_key(4'd0, F_ENT, 5);
        for (int i = 0; i < 6; i++) drive_key(4'(8 + i), F_DIG);
        @(posedge clk); #1;
        key_valid = 1'b0;
        settle_check("t3_overflow");
        pulse_done();
        settle_check("t3_drain");

        do_reset("t4_reset");
        send_key(4'd5, F_ENT, 5);
        send_key(4'd6, 2'b11, 5);
        send_key(4'd6, 2'b00, 5);
        settle_check("t5_ignored");
        for (int i = 1; i <= 5; i++) send_key(4'(i), F_DIG, 4);
        send_key(4'd0, F_ENT, 5);
        settle_check("t4_five");

        drive_key(4'd9, F_DIG);
        drive_key(4'd0, F_ENT);
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (4) @(posedge clk);
        do_reset("t6_midcalc");
        pulse_done();
        settle_check("t6_after");

`ifdef INPUT_SEQ_TIMEOUT_EN
        send_key(4'd4, F_DIG, 5);
        send_key(4'd0, F_ENT, 5);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("tmo_still_busy", int'(busy), 1);
        push_ev(EV_CLR, 0);
        exp_err = 1;
        m_cnt   = 0;
        m_mode  = M_ENTRY;
        model_run();
        repeat (40) @(posedge clk);
        settle_check("tmo_fired");
`endif

        for (int round = 0; round < 25; round++) begin
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n && m_mode != M_WAIT; k++) begin
                rand_key(c, f);
                send_key(c, f, int'($urandom_range(4, 7)));
            end
            settle_check("rnd_entry");
            while (m_mode == M_WAIT) begin
                repeat (4) @(posedge clk);
                n = int'($urandom_range(0, 6));
                for (int k = 0; k < n; k++) begin
                    rand_key(c, f);
                    drive_key(c, f);
                end
                @(posedge clk); #1;
                key_valid = 1'b0;
                settle_check("rnd_wait");
                pulse_done();
                settle_check("rnd_show");
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_done();
                settle_check("rnd_spurious");
            end
        end

        repeat (20) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
